// File: rtl/bus_pkg.sv
// Shared definitions for the host bus fabric: size limits, wait-state type
// and the per-slave region descriptor used by the address decoder.
package bus_pkg;

  localparam int MAX_SLAVES       = 8;
  localparam int WAIT_BITS        = 3;
  localparam int REGION_ADDR_BITS = 32;

  typedef logic [WAIT_BITS-1:0] wait_t;

  // One decoded slave window; base/mask are zero-extended host addresses.
  typedef struct packed {
    logic [REGION_ADDR_BITS-1:0] base;
    logic [REGION_ADDR_BITS-1:0] mask;
    wait_t                       waits;
  } region_t;

  // A region matches when every bit flagged in the mask equals the base.
  function automatic logic region_hit(input logic [REGION_ADDR_BITS-1:0] addr,
                                      input region_t r);
    return ((addr & r.mask) == (r.base & r.mask));
  endfunction

endpackage

// File: rtl/bus_wait_timer.sv
// Wait-state down-counter: loaded at access start, counts down to zero,
// and is cleared immediately when the master abandons the access.
module bus_wait_timer
  import bus_pkg::*;
(
  input  logic  clock,
  input  logic  reset,
  input  logic  load,
  input  wait_t load_value,
  input  logic  abort,
  output logic  busy
);

  wait_t count;

  // The start cycle itself is the first stall cycle, so the register keeps
  // only the remaining stalls (waits - 1) after the load edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (abort) begin
      count <= '0;
    end else if (load) begin
      count <= (load_value != '0) ? wait_t'(load_value - 1'b1) : '0;
    end else if (count != '0) begin
      count <= wait_t'(count - 1'b1);
    end
  end

  assign busy = (count != '0);

endmodule

// File: rtl/host_bus_fabric.sv
// Host bus fabric: decodes the master address into one-hot slave selects,
// inserts per-slave wait states, muxes read data and keeps an open-bus
// latch that answers reads to unmapped space.
module host_bus_fabric
  import bus_pkg::*;
#(
  parameter int                     P_slaves    = 3,
  parameter int                     P_addr_bits = 16,
  parameter int                     P_data_bits = 8,
  parameter logic [P_addr_bits-1:0] P_base  [P_slaves] = '{16'h0000, 16'h2000, 16'h4000},
  parameter logic [P_addr_bits-1:0] P_mask  [P_slaves] = '{16'hE000, 16'hE000, 16'h0000},
  parameter logic [WAIT_BITS-1:0]   P_waits [P_slaves] = '{3'd0, 3'd0, 3'd2},
  parameter logic [P_data_bits-1:0] P_open_init = '1
) (
  input  logic                            I_clock,
  input  logic                            I_reset,
  input  logic [P_addr_bits-1:0]          I_addr,
  input  logic                            I_rdwr,
  input  logic                            I_phy2,
  input  logic [P_data_bits-1:0]          I_wr_data,
  output logic [P_data_bits-1:0]          O_rd_data,
  output logic                            O_ready,
  output logic [P_slaves-1:0]             O_select,
  output logic [P_slaves-1:0]             O_wren,
  input  logic [P_slaves*P_data_bits-1:0] I_slave_data,
  output logic                            O_unmapped
);

  localparam int SEL_BITS = (P_slaves > 1) ? $clog2(P_slaves) : 1;

  region_t                    regions [P_slaves];
  logic [REGION_ADDR_BITS-1:0] addr_ext;
  logic                       hit;
  logic [SEL_BITS-1:0]        sel_idx;
  wait_t                      sel_waits;
  logic                       phy2_q;
  logic                       access_start;
  logic                       busy;
  logic                       done_q;
  logic [P_data_bits-1:0]     open_bus;

  for (genvar g = 0; g < P_slaves; g++) begin : g_region
    assign regions[g].base  = REGION_ADDR_BITS'(P_base[g]);
    assign regions[g].mask  = REGION_ADDR_BITS'(P_mask[g]);
    assign regions[g].waits = P_waits[g];
  end

  assign addr_ext = REGION_ADDR_BITS'(I_addr);

  // Priority decode: scanning from the top down lets the lowest index win.
  always_comb begin
    hit      = 1'b0;
    sel_idx  = '0;
    O_select = '0;
    for (int i = P_slaves - 1; i >= 0; i--) begin
      if (region_hit(addr_ext, regions[i])) begin
        hit     = 1'b1;
        sel_idx = SEL_BITS'(i);
      end
    end
    if (hit) begin
      O_select[sel_idx] = 1'b1;
    end
  end

  assign sel_waits    = hit ? regions[sel_idx].waits : '0;
  assign access_start = I_phy2 & ~phy2_q;

  bus_wait_timer u_timer (
    .clock      (I_clock),
    .reset      (I_reset),
    .load       (access_start),
    .load_value (sel_waits),
    .abort      (~I_phy2),
    .busy       (busy)
  );

  assign O_ready   = ~((access_start & (sel_waits != '0)) | busy);
  assign O_wren    = O_select & {P_slaves{I_phy2 & ~I_rdwr & O_ready & ~I_reset}};
  assign O_rd_data = hit ? I_slave_data[int'(sel_idx)*P_data_bits +: P_data_bits] : open_bus;

  // Registered data phase, used to spot the rising edge that starts an access.
  always_ff @(posedge I_clock) begin
    if (I_reset) begin
      phy2_q <= 1'b0;
    end else begin
      phy2_q <= I_phy2;
    end
  end

  // Open-bus latch follows whatever value last crossed the bus.
  always_ff @(posedge I_clock) begin
    if (I_reset) begin
      open_bus <= P_open_init;
    end else if (I_phy2 & O_ready) begin
      open_bus <= I_rdwr ? O_rd_data : I_wr_data;
    end
  end

  // Unmapped flag fires once per access, on its first completed data cycle.
  always_ff @(posedge I_clock) begin
    if (I_reset) begin
      done_q     <= 1'b0;
      O_unmapped <= 1'b0;
    end else begin
      O_unmapped <= I_phy2 & O_ready & ~done_q & ~hit;
      if (!I_phy2) begin
        done_q <= 1'b0;
      end else if (O_ready) begin
        done_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_host_bus_fabric.sv
// Directed bench for host_bus_fabric: two instances share the stimulus, one
// with the default map and one with a map containing an unmapped hole, an
// overlapping pair of regions and a longer wait count.
module tb_host_bus_fabric;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] addr;
  logic        rdwr;
  logic        phy2;
  logic [7:0]  wr_data;
  logic [23:0] slave_data;

  logic [7:0]  rd_a, rd_b;
  logic        rdy_a, rdy_b;
  logic [2:0]  sel_a, sel_b;
  logic [2:0]  wren_a, wren_b;
  logic        unm_a, unm_b;

  typedef struct {
    string       tag;
    logic [31:0] value;
  } exp_t;

  exp_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;

  always #5 clock = ~clock;

  host_bus_fabric dut_a (
    .I_clock      (clock),
    .I_reset      (reset),
    .I_addr       (addr),
    .I_rdwr       (rdwr),
    .I_phy2       (phy2),
    .I_wr_data    (wr_data),
    .O_rd_data    (rd_a),
    .O_ready      (rdy_a),
    .O_select     (sel_a),
    .O_wren       (wren_a),
    .I_slave_data (slave_data),
    .O_unmapped   (unm_a)
  );

  host_bus_fabric #(
    .P_base  ('{16'h0000, 16'h1000, 16'h4000}),
    .P_mask  ('{16'hE000, 16'hF000, 16'hE000}),
    .P_waits ('{3'd0, 3'd0, 3'd4})
  ) dut_b (
    .I_clock      (clock),
    .I_reset      (reset),
    .I_addr       (addr),
    .I_rdwr       (rdwr),
    .I_phy2       (phy2),
    .I_wr_data    (wr_data),
    .O_rd_data    (rd_b),
    .O_ready      (rdy_b),
    .O_select     (sel_b),
    .O_wren       (wren_b),
    .I_slave_data (slave_data),
    .O_unmapped   (unm_b)
  );

  function automatic logic [31:0] probe(input string tag);
    case (tag)
      "rdy_a":  return 32'(rdy_a);
      "sel_a":  return 32'(sel_a);
      "wren_a": return 32'(wren_a);
      "rd_a":   return 32'(rd_a);
      "unm_a":  return 32'(unm_a);
      "rdy_b":  return 32'(rdy_b);
      "sel_b":  return 32'(sel_b);
      "wren_b": return 32'(wren_b);
      "rd_b":   return 32'(rd_b);
      "unm_b":  return 32'(unm_b);
      default:  return 'x;
    endcase
  endfunction

  task automatic applyStimulus(input logic rst, input logic p2, input logic rw,
                               input logic [15:0] a, input logic [7:0] wd);
    @(posedge clock);
    #1;
    reset   = rst;
    phy2    = p2;
    rdwr    = rw;
    addr    = a;
    wr_data = wd;
  endtask

  task automatic push_exp(input string tag, input logic [31:0] value);
    exp_t e;
    e.tag   = tag;
    e.value = value;
    exp_q.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t        e;
    logic [31:0] obs;
    @(negedge clock);
    while (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      obs = probe(e.tag);
      compared++;
      assert (obs === e.value)
      else begin
        mismatched++;
        $error("[TB] FAIL %s: observed %0h expected %0h", e.tag, obs, e.value);
      end
    end
  endtask

  initial begin
    slave_data = {8'hC8, 8'h77, 8'h3C};
    reset = 1'b1; phy2 = 1'b0; rdwr = 1'b1; addr = 16'h6000; wr_data = 8'h00;

    applyStimulus(1'b1, 1'b0, 1'b1, 16'h6000, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b1, 16'h6000, 8'h00);

    // Idle after reset: ready, catch-all decode, open-bus latch at init value.
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h6000, 8'h00);
    push_exp("rdy_a", 1); push_exp("sel_a", 3'b100); push_exp("wren_a", 0);
    push_exp("sel_b", 3'b000); push_exp("rd_b", 8'hFF); push_exp("unm_b", 0);
    checkOutput();

    // Zero-wait read of slave 0.
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h0005, 8'h00);
    push_exp("sel_a", 3'b001); push_exp("rdy_a", 1); push_exp("rd_a", 8'h3C); push_exp("wren_a", 0);
    checkOutput();
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h0005, 8'h00);
    push_exp("rdy_a", 1); push_exp("rd_a", 8'h3C); push_exp("unm_a", 0);
    checkOutput();
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0005, 8'h00);
    checkOutput();

    // Two-wait write to slave 2 on the default map; unmapped write on map B.
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h8000, 8'hA5);
    push_exp("sel_a", 3'b100); push_exp("rdy_a", 0); push_exp("wren_a", 0);
    push_exp("rdy_b", 1); push_exp("wren_b", 0); push_exp("unm_b", 0);
    checkOutput();
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h8000, 8'hA5);
    push_exp("rdy_a", 0); push_exp("wren_a", 0); push_exp("unm_b", 1);
    checkOutput();
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h8000, 8'hA5);
    push_exp("rdy_a", 1); push_exp("wren_a", 3'b100); push_exp("unm_b", 0);
    checkOutput();
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h8000, 8'h00);
    push_exp("wren_a", 0); push_exp("rd_b", 8'hA5);
    checkOutput();

    // Four-wait write of 5A to slave 2 on map B, then unmapped read of $6000.
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h4000, 8'h5A);
    push_exp("sel_b", 3'b100); push_exp("rdy_b", 0); push_exp("wren_b", 0);
    checkOutput();
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h4000, 8'h5A);
    checkOutput();
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h4000, 8'h5A);
    checkOutput();
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h4000, 8'h5A);
    push_exp("rdy_b", 0); push_exp("wren_b", 0);
    checkOutput();
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h4000, 8'h5A);
    push_exp("rdy_b", 1); push_exp("wren_b", 3'b100);
    checkOutput();
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h6000, 8'h00);
    checkOutput();
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h6000, 8'h00);
    push_exp("sel_b", 3'b000); push_exp("rdy_b", 1); push_exp("rd_b", 8'h5A); push_exp("unm_b", 0);
    checkOutput();
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h6000, 8'h00);
    push_exp("unm_b", 1);
    checkOutput();

    // Overlapping regions 0 and 1 on map B: lowest index wins.
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h1000, 8'h00);
    push_exp("unm_b", 0); push_exp("sel_b", 3'b001); push_exp("rd_b", 8'h3C); push_exp("sel_a", 3'b001);
    checkOutput();

    // Reset on the first wait cycle of a slave-2 write.
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h8000, 8'h99);
    push_exp("rdy_a", 0); push_exp("wren_a", 0);
    checkOutput();
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h8000, 8'h99);
    push_exp("wren_a", 0); push_exp("wren_b", 0);
    checkOutput();
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h8000, 8'h99);
    push_exp("rdy_a", 1); push_exp("wren_a", 0); push_exp("rd_b", 8'hFF); push_exp("unm_b", 0);
    checkOutput();

    // Abandon a four-wait access, then a zero-wait slave-0 read must not stall.
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h4000, 8'h33);
    push_exp("rdy_b", 0); push_exp("wren_b", 0);
    checkOutput();
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h4000, 8'h33);
    push_exp("rdy_b", 0); push_exp("wren_b", 0);
    checkOutput();
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h0005, 8'h00);
    push_exp("rdy_b", 1); push_exp("sel_b", 3'b001); push_exp("rd_b", 8'h3C); push_exp("wren_b", 0);
    push_exp("rdy_a", 1); push_exp("wren_a", 0);
    checkOutput();
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0000, 8'h00);
    checkOutput();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
